digit_bbox_detect: RTL

Scans the grayscale pixel stream of each frame and computes the bounding box of the handwritten digit: the top, bottom, left and right coordinates of all foreground (dark) pixels. The block sits upstream of the LCD overlay stage and produces the `Upper_data` / `Lower_data` / `Lift_data` / `Right_data` boundary values that the overlay consumes. It also flags whether a digit was present in the frame. Results update once per frame and hold steady for the whole following frame.

---
 rtl/digit_bbox_detect.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/digit_bbox_detect.sv
// digit_bbox_detect
// Scans the grayscale pixel stream of each frame and reports the bounding box
// of the dark (foreground) pixels, plus a flag saying whether enough dark
// pixels were seen to call it a digit. Results update once per frame, two
// clocks after the last pixel, and hold until the next completed frame.
//
// Ports:
//   clk          pixel clock
//   rst          synchronous active-high reset
//   de           pixel valid; hcount/lcount/datain sampled only when high
//   hcount       horizontal coordinate of the current pixel
//   lcount       vertical coordinate of the current pixel
//   datain       grayscale pixel value (dark = value below THRESHOLD)
//   Upper_data   minimum lcount of foreground pixels in last valid frame
//   Lower_data   maximum lcount
//   Lift_data    minimum hcount
//   Right_data   maximum hcount
//   digit_found  last completed frame held >= MIN_PIXELS foreground pixels
//   frame_done   one-cycle pulse when the outputs have just been updated
//   o_dbg_state  current FSM state (IDLE=0, SCAN=1, LATCH=2)
//
// Handshake: no back-pressure. Each cycle with de high carries one pixel;
// cycles with de low are ignored. Pixels arriving in the LATCH cycle are
// dropped, which is safe because blanking always separates frames.
module digit_bbox_detect #(
  parameter int         H_ACTIVE   = 480,
  parameter int         V_ACTIVE   = 272,
  parameter logic [7:0] THRESHOLD  = 8'd128,
  parameter int         MIN_PIXELS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       de,
  input  logic [8:0] hcount,
  input  logic [8:0] lcount,
  input  logic [7:0] datain,
  output logic [8:0] Upper_data,
  output logic [8:0] Lower_data,
  output logic [8:0] Lift_data,
  output logic [8:0] Right_data,
  output logic       digit_found,
  output logic       frame_done,
  output logic [1:0] o_dbg_state
);

  localparam logic [8:0]  H_LAST  = 9'(H_ACTIVE - 1);
  localparam logic [8:0]  V_LAST  = 9'(V_ACTIVE - 1);
  localparam logic [16:0] MIN_CNT = 17'(MIN_PIXELS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;

  logic [8:0]  r_min_l, r_max_l, r_min_h, r_max_h;
  logic [16:0] r_fg_cnt;
  logic [8:0]  w_min_l_nxt, w_max_l_nxt, w_min_h_nxt, w_max_h_nxt;
  logic [16:0] w_fg_cnt_nxt;

  logic [8:0]  r_upper, r_lower, r_lift, r_right;
  logic        r_found, r_done;
  logic [8:0]  w_upper_nxt, w_lower_nxt, w_lift_nxt, w_right_nxt;
  logic        w_found_nxt, w_done_nxt;

  // Base values the current pixel is folded into: either the running
  // registers, or the initial values when this pixel starts a new frame.
  logic [8:0]  w_b_min_l, w_b_max_l, w_b_min_h, w_b_max_h;
  logic [16:0] w_b_cnt;
  logic        w_fold_en;

  logic w_sof, w_eof, w_fg;

  assign w_sof = de && (hcount == 9'd0)   && (lcount == 9'd0);
  assign w_eof = de && (hcount == H_LAST) && (lcount == V_LAST);
  assign w_fg  = de && (datain < THRESHOLD);

  always_comb begin
    w_state_nxt  = r_state;
    w_upper_nxt  = r_upper;
    w_lower_nxt  = r_lower;
    w_lift_nxt   = r_lift;
    w_right_nxt  = r_right;
    w_found_nxt  = r_found;
    w_done_nxt   = 1'b0;
    w_fold_en    = 1'b0;
    w_b_min_l    = r_min_l;
    w_b_max_l    = r_max_l;
    w_b_min_h    = r_min_h;
    w_b_max_h    = r_max_h;
    w_b_cnt      = r_fg_cnt;

    case (r_state)
      S_IDLE: begin
        if (w_sof) begin
          w_fold_en   = 1'b1;
          w_b_min_l   = 9'h1FF;
          w_b_max_l   = 9'd0;
          w_b_min_h   = 9'h1FF;
          w_b_max_h   = 9'd0;
          w_b_cnt     = 17'd0;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        w_fold_en = 1'b1;
        // A SOF here means the previous EOF was lost: restart silently.
        if (w_sof) begin
          w_b_min_l = 9'h1FF;
          w_b_max_l = 9'd0;
          w_b_min_h = 9'h1FF;
          w_b_max_h = 9'd0;
          w_b_cnt   = 17'd0;
        end else if (w_eof) begin
          w_state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        w_done_nxt = 1'b1;
        if (r_fg_cnt >= MIN_CNT) begin
          w_upper_nxt = r_min_l;
          w_lower_nxt = r_max_l;
          w_lift_nxt  = r_min_h;
          w_right_nxt = r_max_h;
          w_found_nxt = 1'b1;
        end else begin
          w_found_nxt = 1'b0;
        end
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_min_l_nxt  = r_min_l;
    w_max_l_nxt  = r_max_l;
    w_min_h_nxt  = r_min_h;
    w_max_h_nxt  = r_max_h;
    w_fg_cnt_nxt = r_fg_cnt;
    if (w_fold_en) begin
      w_min_l_nxt  = (w_fg && (lcount < w_b_min_l)) ? lcount : w_b_min_l;
      w_max_l_nxt  = (w_fg && (lcount > w_b_max_l)) ? lcount : w_b_max_l;
      w_min_h_nxt  = (w_fg && (hcount < w_b_min_h)) ? hcount : w_b_min_h;
      w_max_h_nxt  = (w_fg && (hcount > w_b_max_h)) ? hcount : w_b_max_h;
      w_fg_cnt_nxt = (w_fg && (w_b_cnt != 17'h1FFFF)) ? w_b_cnt + 17'd1 : w_b_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_min_l  <= 9'h1FF;
      r_max_l  <= 9'd0;
      r_min_h  <= 9'h1FF;
      r_max_h  <= 9'd0;
      r_fg_cnt <= 17'd0;
      r_upper  <= 9'd0;
      r_lower  <= 9'd0;
      r_lift   <= 9'd0;
      r_right  <= 9'd0;
      r_found  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_min_l  <= w_min_l_nxt;
      r_max_l  <= w_max_l_nxt;
      r_min_h  <= w_min_h_nxt;
      r_max_h  <= w_max_h_nxt;
      r_fg_cnt <= w_fg_cnt_nxt;
      r_upper  <= w_upper_nxt;
      r_lower  <= w_lower_nxt;
      r_lift   <= w_lift_nxt;
      r_right  <= w_right_nxt;
      r_found  <= w_found_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign Upper_data  = r_upper;
  assign Lower_data  = r_lower;
  assign Lift_data   = r_lift;
  assign Right_data  = r_right;
  assign digit_found = r_found;
  assign frame_done  = r_done;
  assign o_dbg_state = r_state;

endmodule
